// File: rtl/ppu_vga_scanout.sv
// PPU frame-buffer capture and 640x480 VGA scan-out with 2x doubling and NES palette.
// Counters and output pipeline advance on PIX_EN; frame-buffer writes land on any clock.
module ppu_vga_scanout #(
  parameter int          H_VISIBLE     = 640,
  parameter int          H_FRONT       = 16,
  parameter int          H_SYNC        = 96,
  parameter int          H_BACK        = 48,
  parameter int          V_VISIBLE     = 480,
  parameter int          V_FRONT       = 10,
  parameter int          V_SYNC        = 2,
  parameter int          V_BACK        = 33,
  parameter int          X_OFFSET      = 64,
  parameter logic [5:0]  BORDER_COLOUR = 6'h0F
) (
  input  logic       PPU_SLOW_CLOCK,
  input  logic       RST,
  input  logic       PIX_EN,
  input  logic       PIX_WE,
  input  logic [7:0] PIX_X,
  input  logic [7:0] PIX_Y,
  input  logic [5:0] PIX_DATA,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       FRAME_START
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int FB_W     = 256;
  localparam int FB_H     = 240;
  localparam int FB_DEPTH = FB_W * FB_H;

  logic [9:0]  r_h_cnt, r_v_cnt;
  logic        w_h_last, w_v_last;
  logic        w_visible, w_hs, w_vs, w_window;
  logic [7:0]  w_fb_x, w_fb_y;
  logic [15:0] w_rd_addr, w_wr_addr;
  logic        w_wr_ok;
  logic [5:0]  r_fb [FB_DEPTH];
  logic        r_vis1, r_hs1, r_vs1, r_win1;
  logic [5:0]  r_rd_idx;
  logic [5:0]  w_idx;
  logic [23:0] w_rgb;
  logic        r_hs, r_vs, r_blank_n, r_frame_start;
  logic [23:0] r_rgb;

  assign w_h_last = (r_h_cnt == 10'(H_TOTAL - 1));
  assign w_v_last = (r_v_cnt == 10'(V_TOTAL - 1));

  always_ff @(posedge PPU_SLOW_CLOCK) begin
    if (RST) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (PIX_EN) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + 10'd1;
      end else begin
        r_h_cnt <= r_h_cnt + 10'd1;
      end
    end
  end

  assign w_visible = (r_h_cnt < 10'(H_VISIBLE)) && (r_v_cnt < 10'(V_VISIBLE));
  assign w_hs      = !((r_h_cnt >= 10'(H_VISIBLE + H_FRONT)) &&
                       (r_h_cnt <  10'(H_VISIBLE + H_FRONT + H_SYNC)));
  assign w_vs      = !((r_v_cnt >= 10'(V_VISIBLE + V_FRONT)) &&
                       (r_v_cnt <  10'(V_VISIBLE + V_FRONT + V_SYNC)));
  assign w_window  = w_visible && (r_h_cnt >= 10'(X_OFFSET)) &&
                     (r_h_cnt < 10'(X_OFFSET + 2 * FB_W));

  // Outside the image window the address is parked at 0 so it never leaves the buffer.
  assign w_fb_x    = 8'((r_h_cnt - 10'(X_OFFSET)) >> 1);
  assign w_fb_y    = 8'(r_v_cnt >> 1);
  assign w_rd_addr = w_window ? {w_fb_y, w_fb_x} : 16'd0;

  assign w_wr_addr = {PIX_Y, PIX_X};
  assign w_wr_ok   = PIX_WE && !RST && (PIX_Y < 8'(FB_H));

  always_ff @(posedge PPU_SLOW_CLOCK) begin
    if (w_wr_ok) r_fb[w_wr_addr] <= PIX_DATA;
  end

  function automatic logic [23:0] f_palette(input logic [5:0] idx);
    case (idx)
      6'h00: f_palette = 24'h7C7C7C;  6'h01: f_palette = 24'h0000FC;  6'h02: f_palette = 24'h0000BC;  6'h03: f_palette = 24'h4428BC;
      6'h04: f_palette = 24'h940084;  6'h05: f_palette = 24'hA80020;  6'h06: f_palette = 24'hA81000;  6'h07: f_palette = 24'h881400;
      6'h08: f_palette = 24'h503000;  6'h09: f_palette = 24'h007800;  6'h0A: f_palette = 24'h006800;  6'h0B: f_palette = 24'h005800;
      6'h0C: f_palette = 24'h004058;  6'h10: f_palette = 24'hBCBCBC;  6'h11: f_palette = 24'h0078F8;  6'h12: f_palette = 24'h0058F8;
      6'h13: f_palette = 24'h6844FC;  6'h14: f_palette = 24'hD800CC;  6'h15: f_palette = 24'hE40058;  6'h16: f_palette = 24'hF83800;
      6'h17: f_palette = 24'hE45C10;  6'h18: f_palette = 24'hAC7C00;  6'h19: f_palette = 24'h00B800;  6'h1A: f_palette = 24'h00A800;
      6'h1B: f_palette = 24'h00A844;  6'h1C: f_palette = 24'h008888;  6'h20: f_palette = 24'hF8F8F8;  6'h21: f_palette = 24'h3CBCFC;
      6'h22: f_palette = 24'h6888FC;  6'h23: f_palette = 24'h9878F8;  6'h24: f_palette = 24'hF878F8;  6'h25: f_palette = 24'hF85898;
      6'h26: f_palette = 24'hF87858;  6'h27: f_palette = 24'hFCA044;  6'h28: f_palette = 24'hF8B800;  6'h29: f_palette = 24'hB8F818;
      6'h2A: f_palette = 24'h58D854;  6'h2B: f_palette = 24'h58F898;  6'h2C: f_palette = 24'h00E8D8;  6'h2D: f_palette = 24'h787878;
      6'h30: f_palette = 24'hFFFFFF;  6'h31: f_palette = 24'hA4E4FC;  6'h32: f_palette = 24'hB8B8F8;  6'h33: f_palette = 24'hD8B8F8;
      6'h34: f_palette = 24'hF8B8F8;  6'h35: f_palette = 24'hF8A4C0;  6'h36: f_palette = 24'hF0D0B0;  6'h37: f_palette = 24'hFCE0A8;
      6'h38: f_palette = 24'hF8D878;  6'h39: f_palette = 24'hD8F878;  6'h3A: f_palette = 24'hB8F8B8;  6'h3B: f_palette = 24'hB8F8D8;
      6'h3C: f_palette = 24'h00FCFC;  6'h3D: f_palette = 24'hF8D8F8;
      default: f_palette = 24'h000000;
    endcase
  endfunction

  assign w_idx = r_win1 ? r_rd_idx : BORDER_COLOUR;
  assign w_rgb = f_palette(w_idx);

  always_ff @(posedge PPU_SLOW_CLOCK) begin
    if (RST) begin
      r_vis1    <= 1'b0;
      r_hs1     <= 1'b1;
      r_vs1     <= 1'b1;
      r_win1    <= 1'b0;
      r_rd_idx  <= '0;
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
      r_blank_n <= 1'b0;
      r_rgb     <= '0;
    end else if (PIX_EN) begin
      r_vis1    <= w_visible;
      r_hs1     <= w_hs;
      r_vs1     <= w_vs;
      r_win1    <= w_window;
      r_rd_idx  <= r_fb[w_rd_addr];
      r_hs      <= r_hs1;
      r_vs      <= r_vs1;
      r_blank_n <= r_vis1;
      r_rgb     <= r_vis1 ? w_rgb : 24'h000000;
    end
  end

  always_ff @(posedge PPU_SLOW_CLOCK) begin
    if (RST) r_frame_start <= 1'b0;
    else     r_frame_start <= PIX_EN && w_h_last && w_v_last;
  end

  assign VGA_HS      = r_hs;
  assign VGA_VS      = r_vs;
  assign VGA_BLANK_N = r_blank_n;
  assign VGA_R       = r_rgb[23:16];
  assign VGA_G       = r_rgb[15:8];
  assign VGA_B       = r_rgb[7:0];
  assign FRAME_START = r_frame_start;

endmodule
